// File: rtl/expr_emitter.sv
// Serializes a latched operand/operator set into an ASCII "d(op d)*" stream over valid/ready.
// Optional load validation is enabled by defining EXPR_EMITTER_CHECK_EN.
module expr_emitter #(
    parameter int MAX_TERMS = 8
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   start,
    input  logic [3:0]             n_terms,
    input  logic [4*MAX_TERMS-1:0] digits,
    input  logic [MAX_TERMS-2:0]   ops,
    output logic                   out_valid,
    output logic [7:0]             out_data,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [1:0]             dbg_state
);

    localparam logic [3:0] MAX_N = 4'(MAX_TERMS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIGIT = 2'd1,
        S_OP    = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  k_q, k_d;
    logic [3:0]  n_q, n_d;
    logic [3:0]  dig_q [16];
    logic [3:0]  dig_d [16];
    logic [3:0]  in_dig [16];
    logic [15:0] ops_q, ops_d, in_ops;
    logic [3:0]  n_eff;
    logic        bad, xfer, fin, rej;

    logic        ov_d, ol_d, busy_d;
    logic [7:0]  od_d;

    // Terms and operators are padded to 16 entries so the 4-bit index always fits.
    for (genvar g = 0; g < 16; g++) begin : g_in
        if (g < MAX_TERMS) begin : g_dig
            assign in_dig[g] = digits[4*g +: 4];
        end else begin : g_dig_pad
            assign in_dig[g] = 4'd0;
        end
        if (g < MAX_TERMS - 1) begin : g_op
            assign in_ops[g] = ops[g];
        end else begin : g_op_pad
            assign in_ops[g] = 1'b0;
        end
    end

`ifdef EXPR_EMITTER_CHECK_EN
    always_comb begin
        bad = (n_terms == 4'd0) || (n_terms > MAX_N);
        for (int i = 0; i < 16; i++) begin
            if (4'(i) < n_terms && in_dig[i] > 4'd9) bad = 1'b1;
        end
        n_eff = n_terms;
    end
`else
    always_comb begin
        bad = 1'b0;
        if (n_terms == 4'd0)       n_eff = 4'd1;
        else if (n_terms > MAX_N)  n_eff = MAX_N;
        else                       n_eff = n_terms;
    end
`endif

    // A character moves when out_valid && out_ready at a rising edge; while
    // out_valid is high without ready, out_data/out_last hold and valid stays up.
    assign xfer = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q <= S_IDLE;
            k_q     <= 4'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    always_ff @(posedge clk) begin
        n_q   <= n_d;
        ops_q <= ops_d;
        dig_q <= dig_d;
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        ops_d   = ops_q;
        dig_d   = dig_q;
        fin     = 1'b0;
        rej     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && bad) begin
                    rej = 1'b1;
                end else if (start) begin
                    n_d     = n_eff;
                    ops_d   = in_ops;
                    dig_d   = in_dig;
                    k_d     = 4'd0;
                    state_d = S_DIGIT;
                end
            end
            S_DIGIT: begin
                if (xfer) begin
                    if (k_q == n_q - 4'd1) begin
                        state_d = S_IDLE;
                        fin     = 1'b1;
                    end else begin
                        state_d = S_OP;
                    end
                end
            end
            S_OP: begin
                if (xfer) begin
                    k_d     = k_q + 4'd1;
                    state_d = S_DIGIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they are registered yet cycle-aligned.
    always_comb begin
        ov_d   = (state_d != S_IDLE);
        busy_d = (state_d != S_IDLE);
        ol_d   = (state_d == S_DIGIT) && (k_d == n_d - 4'd1);
        case (state_d)
            S_DIGIT: od_d = 8'h30 + {4'h0, dig_d[k_d]};
            S_OP:    od_d = ops_d[k_d] ? 8'h2A : 8'h2B;
            default: od_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            out_valid <= ov_d;
            out_data  <= od_d;
            out_last  <= ol_d;
            busy      <= busy_d;
            done      <= fin;
            err       <= rej;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_expr_emitter.sv
// Self-checking bench for expr_emitter: a string model builds the expected character queue.
// Build with EXPR_EMITTER_CHECK_EN to exercise load rejection.
module tb_expr_emitter;

    localparam int MT = 8;

    logic          clk = 1'b0;
    logic          clr_n = 1'b0;
    logic          start = 1'b0;
    logic [3:0]    n_terms = 4'd0;
    logic [4*MT-1:0] digits = '0;
    logic [MT-2:0] ops = '0;
    logic          out_ready = 1'b1;
    logic          out_valid, out_last, busy, done, err;
    logic [7:0]    out_data;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    expr_emitter #(.MAX_TERMS(MT)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .n_terms(n_terms),
        .digits(digits), .ops(ops), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done),
        .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference: the expression string as text, one byte per character.
    task automatic build_expected(input int n, input logic [4*MT-1:0] d, input logic [MT-2:0] o);
        int ne;
        ne = n;
`ifndef EXPR_EMITTER_CHECK_EN
        if (ne == 0) ne = 1;
        if (ne > MT) ne = MT;
`endif
        exp_q.delete();
        for (int i = 0; i < ne; i++) begin
            exp_q.push_back(8'h30 + 8'(d[4*i +: 4]));
            if (i < ne - 1) exp_q.push_back(o[i] ? 8'h2A : 8'h2B);
        end
    endtask

    task automatic load(input int n, input logic [4*MT-1:0] d, input logic [MT-2:0] o);
        build_expected(n, d, o);
        start = 1'b1; n_terms = 4'(n); digits = d; ops = o;
        @(negedge clk);
        start = 1'b0; n_terms = 4'($urandom); digits = 32'($urandom); ops = 7'($urandom);
    endtask

    // mode 0: ready high, 1: random ready, 2: ready low 3 cycles on the first '+'
    task automatic stream_check(input int mode, input bit poke);
        int   cyc;
        int   lows;
        bit   hold;
        bit   first;
        logic [7:0] held;
        cyc = 0; lows = 0; hold = 0; first = 1; held = 8'h00;
        while (exp_q.size() > 0 && cyc < 300) begin
            if (first) begin
                checks++;
                if (out_valid !== 1'b1 || busy !== 1'b1)
                    begin errors++; $display("FAIL first_valid: valid=%b busy=%b want 1 1", out_valid, busy); end
                first = 0;
            end
            if (hold) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held)
                    begin errors++; $display("FAIL hold: valid=%b data=%h want 1 %h", out_valid, out_data, held); end
            end
            if (poke) begin
                start = (cyc == 2);
            end
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 2) != 0);
                default: begin
                    out_ready = !(exp_q[0] == 8'h2B && lows < 3);
                    if (!out_ready) lows++;
                end
            endcase
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== exp_q[0] || out_last !== (exp_q.size() == 1) || done !== 1'b0)
                    begin errors++; $display("FAIL char: data=%h last=%b done=%b want %h %b 0", out_data, out_last, done, exp_q[0], exp_q.size() == 1); end
                void'(exp_q.pop_front());
                hold = 0;
            end else if (out_valid) begin
                hold = 1;
                held = out_data;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (cyc >= 300)
            begin errors++; $display("FAIL timeout: %0d chars still expected", exp_q.size()); end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL done: done=%b busy=%b valid=%b want 1 0 0", done, busy, out_valid); end
    endtask

    task automatic idle_check();
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || err !== 1'b0)
            begin errors++; $display("FAIL idle: done=%b busy=%b valid=%b data=%h err=%b want 0 0 0 00 0", done, busy, out_valid, out_data, err); end
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0 || dbg_state !== 2'd0)
            begin errors++; $display("FAIL reset: valid=%b data=%h last=%b busy=%b done=%b err=%b st=%0d want all 0",
                out_valid, out_data, out_last, busy, done, err, dbg_state); end
        clr_n = 1'b1;
        idle_check();
    endtask

    task automatic test_basic();
        load(3, 32'h0000_0321, 7'b0000010);
        stream_check(0, 0);
        idle_check();
    endtask

    task automatic test_single();
        load(1, 32'h0000_0007, 7'b0);
        stream_check(0, 0);
        idle_check();
    endtask

    task automatic test_backpressure();
        load(2, 32'h0000_0094, 7'b0);
        stream_check(2, 0);
        idle_check();
    endtask

    task automatic test_back_to_back();
        load(4, 32'h0000_5813, 7'b0000101);
        stream_check(0, 1);
        load(3, 32'h0000_0246, 7'b0000011);
        stream_check(1, 0);
        idle_check();
    endtask

    task automatic test_reset_mid();
        load(4, 32'h0000_4321, 7'b0000000);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            begin errors++; $display("FAIL reset_mid: valid=%b data=%h last=%b busy=%b done=%b want all 0",
                out_valid, out_data, out_last, busy, done); end
        clr_n = 1'b1;
        idle_check();
        load(2, 32'h0000_0068, 7'b1);
        stream_check(0, 0);
        idle_check();
    endtask

    task automatic test_load_check();
`ifdef EXPR_EMITTER_CHECK_EN
        for (int t = 0; t < 2; t++) begin
            start = 1'b1;
            n_terms = (t == 0) ? 4'd0 : 4'd2;
            digits = 32'h0000_00C5; ops = 7'b0;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
                begin errors++; $display("FAIL reject_%0d: err=%b valid=%b busy=%b want 1 0 0", t, err, out_valid, busy); end
            idle_check();
        end
`else
        load(2, 32'h0000_00C5, 7'b0);
        stream_check(0, 0);
        idle_check();
        load(0, 32'h0000_0007, 7'b0);
        stream_check(0, 0);
        idle_check();
`endif
    endtask

    task automatic test_random();
        int n;
        logic [4*MT-1:0] d;
        logic [MT-2:0] o;
        for (int it = 0; it < 12; it++) begin
`ifdef EXPR_EMITTER_CHECK_EN
            n = $urandom_range(1, MT);
            for (int i = 0; i < MT; i++) d[4*i +: 4] = 4'($urandom_range(0, 9));
`else
            n = $urandom_range(0, 15);
            d = 32'($urandom);
`endif
            o = 7'($urandom);
            load(n, d, o);
            stream_check(1, ($urandom_range(0, 1) == 1));
            if ($urandom_range(0, 1) == 1) idle_check();
        end
        idle_check();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_load_check();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/expr_emitter.md
# expr_emitter

Serializes a loaded arithmetic expression into an ASCII character stream of the form digit (op digit)*, one byte per transfer, with single-digit operands and `+`/`*` operators. It is the transmit side of the expression-character interface: its output feeds the expression string recognizer or a character sink, producing only strings that the recognizer accepts. An operand/operator set is loaded with a one-cycle `start`, and a valid/ready handshake paces the output.

## Interface
- `MAX_TERMS`, default 8: maximum operand count; legal range 2..15.
- `clk` input 1: sole clock; all logic on the rising edge.
- `clr_n` input 1: reset, synchronous, active-low.
- `start` input 1: load request; sampled only in IDLE.
- `n_terms` input 4: operand count for this load.
- `digits` input 4*MAX_TERMS: BCD operands; term i is at [4i+3:4i]; term 0 is emitted first.
- `ops` input MAX_TERMS-1: operator i sits between term i and term i+1; 0 = `+` (8'h2B), 1 = `*` (8'h2A).
- `out_valid` output 1: `out_data` holds a character.
- `out_data` output 8: ASCII character.
- `out_ready` input 1: sink accepts; a transfer occurs on a cycle with `out_valid && out_ready`.
- `out_last` output 1: high with the final character of the expression.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse after the final transfer.
- `err` output 1: one-cycle pulse when a load is rejected (see Configuration).

## Operation
- States: IDLE, DIGIT, OP.
- **IDLE**
  - `start=1` with a legal load: latch `digits`, `ops` and `n_terms`; clear term index k; go to DIGIT.
  - `start=0`: stay in IDLE.
- **DIGIT**
  - `out_data` = 8'h30 + term k; `out_valid` = 1.
  - `out_last` = 1 when k == n_terms-1.
  - On a transfer with k == n_terms-1: go to IDLE and pulse `done`.
  - On a transfer otherwise: go to OP.
- **OP**
  - `out_data` = 8'h2B or 8'h2A according to ops[k]; `out_valid` = 1.
  - On a transfer: k <= k+1; go to DIGIT.
- Expression length is 2*n_terms-1 characters.
- Always emits a digit first, never two consecutive operators, and always ends on a digit.
- `start` outside IDLE is ignored: no latch, no `err`.
- Input buses are don't-care after the latch cycle.
- Output stability: while `out_valid=1 && out_ready=0`, `out_data` and `out_last` hold unchanged.
- `out_valid` never deasserts without a transfer, except on reset.
- `out_valid=0` in IDLE; `out_data` = 8'h00 in IDLE.
- Reset values (`clr_n=0` at an edge, including mid-expression):
  - state IDLE, k=0.
  - `out_valid`, `out_last`, `busy`, `done`, `err` all 0; `out_data` = 8'h00.
  - Any partial expression is abandoned; no `done`.

## Timing
- All outputs are registered.
- `start` accepted at edge t: `out_valid=1` with the first digit from t+1.
- With `out_ready` held high: one character per cycle, so the final transfer occurs at edge t+2n-1.
  - `done` and `busy=0` are visible in the following cycle.
- A new `start` in the cycle where `done=1` is accepted (back-to-back loads).
  - Minimum period between loads with `out_ready` high is 2n cycles.
- `err` pulses the cycle after the rejected `start` edge; state stays IDLE.
- `clr_n` has priority over `start` and over any transfer at the same edge.

## Configuration
- Macro: `EXPR_EMITTER_CHECK_EN`.
- **Defined:** a load is rejected (`err` pulse, no output, stays IDLE) if either condition holds:
  - n_terms == 0 or n_terms > MAX_TERMS;
  - any used term (i < n_terms) > 9.
- **Undefined:** `err` is tied 0 and loads are never rejected.
  - n_terms == 0 is treated as 1; n_terms > MAX_TERMS is clamped to MAX_TERMS.
  - Out-of-range BCD values are emitted unchecked as 8'h30 + value, e.g. 4'hA gives 8'h3A.

## Test plan
- **Basic expression.** Stimulus: n_terms=3, digits {3,2,1}, ops=2'b10, `out_ready`=1. Required response: stream 31 2B 32 2A 33 ("1+2*3") on consecutive cycles; `out_last` only on 33; `done` the next cycle.
- **Single operand.** Stimulus: n_terms=1, digit 7. Required response: one byte 37 with `out_last`=1; `done` follows; no operator byte.
- **Backpressure.** Stimulus: n_terms=2, digits {9,4}, op `+`; `out_ready` low for 3 cycles while 2B is presented. Required response: 2B held stable, no extra bytes, then 39; stream is 34 2B 39.
- **Busy and back-to-back.** Stimulus: `start` mid-stream, then a second load in the `done` cycle. Required response: the mid-stream `start` is ignored; the second expression's first digit appears the next cycle.
- **Reset mid-operation.** Stimulus: `clr_n`=0 after 2 transfers of a 4-term expression. Required response: all outputs 0 at the next cycle; no `done`; a new load after release works normally.
- **Load check (macro defined).** Stimulus: n_terms=0, then a used digit 4'hC. Required response: `err` pulses each time with no output. With the macro undefined, 4'hC emits 3C.
